// File: rtl/result_store_arbiter_if.sv
// Bus interfaces for result_store_arbiter.
//   rsa_req_if : per-core result request bus (cores are master, arbiter is slave)
//     req_valid/req_hit [CORES], req_x/req_y/req_scale (core i at [i*W +: W]),
//     req_ack [CORES] one-hot accept returned by the arbiter.
//   rsa_ws_if  : result-store write port (arbiter is master, store is slave)
//     ws_valid, ws_x, ws_y, ws_scale, ws_exit driven by arbiter; ws_ready from store.

interface rsa_req_if #(
   parameter int unsigned CORES     = 4,
   parameter int unsigned XBITS     = 10,
   parameter int unsigned YBITS     = 10,
   parameter int unsigned SCALEBITS = 6
);
   logic [CORES-1:0]           req_valid;
   logic [CORES-1:0]           req_hit;
   logic [CORES*XBITS-1:0]     req_x;
   logic [CORES*YBITS-1:0]     req_y;
   logic [CORES*SCALEBITS-1:0] req_scale;
   logic [CORES-1:0]           req_ack;

   modport master (output req_valid, req_hit, req_x, req_y, req_scale, input req_ack);
   modport slave  (input req_valid, req_hit, req_x, req_y, req_scale, output req_ack);
endinterface

interface rsa_ws_if #(
   parameter int unsigned XBITS     = 10,
   parameter int unsigned YBITS     = 10,
   parameter int unsigned SCALEBITS = 6
);
   logic                 ws_valid;
   logic                 ws_ready;
   logic [XBITS-1:0]     ws_x;
   logic [YBITS-1:0]     ws_y;
   logic [SCALEBITS-1:0] ws_scale;
   logic                 ws_exit;

   modport master (output ws_valid, ws_x, ws_y, ws_scale, ws_exit, input ws_ready);
   modport slave  (input ws_valid, ws_x, ws_y, ws_scale, ws_exit, output ws_ready);
endinterface

// File: rtl/result_store_arbiter.sv
// result_store_arbiter: shares the single result-store write port between CORES
// classifier processors. Round-robin grant over per-core results, hits buffered in
// a first-word fall-through FIFO, misses acknowledged and dropped. On exit_req the
// block drains all pending work and then emits one exit-code record.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req   (rsa_req_if)    per-core valid/hit/x/y/scale in, one-hot comb req_ack out
//   exit_req/exit_x/exit_y  level exit request and exit record payload
//   exit_ack              one-cycle pulse once the exit record has been stored
//   ws    (rsa_ws_if)     FIFO head presented to the result store, popped on ready
//   hit_count             saturating count of pushed hits, cleared by clear
//   clear                 synchronous clear of the counters
//   busy                  sequencing an exit or FIFO holds entries
//   stall_cycles          (only with RESULT_ARB_STALL_CNT_EN) saturating count of
//                         cycles with ws_valid & ~ws_ready, cleared by clear
//
// Optional feature macro: RESULT_ARB_STALL_CNT_EN

module result_store_arbiter #(
   parameter int unsigned CORES      = 4,
   parameter int unsigned XBITS      = 10,
   parameter int unsigned YBITS      = 10,
   parameter int unsigned SCALEBITS  = 6,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   rsa_req_if.slave         req,
   input  logic             exit_req,
   input  logic [XBITS-1:0] exit_x,
   input  logic [YBITS-1:0] exit_y,
   output logic             exit_ack,
   rsa_ws_if.master         ws,
   output logic [15:0]      hit_count,
   input  logic             clear,
   output logic             busy
`ifdef RESULT_ARB_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   localparam int unsigned CW = $clog2(CORES);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [XBITS-1:0]     x;
      logic [YBITS-1:0]     y;
      logic [SCALEBITS-1:0] scale;
      logic                 ext;
   } entry_t;

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_DRAIN = 3'd1,
      S_EXIT  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]        rr_ptr;
   logic [CW-1:0]        winner;
   logic                 any_valid;
   logic [2*CORES-1:0]   dbl_valid;
   logic [CORES-1:0]     rot_valid;

   logic                 sel_hit;
   logic [XBITS-1:0]     sel_x;
   logic [YBITS-1:0]     sel_y;
   logic [SCALEBITS-1:0] sel_scale;

   logic                 grant_en;
   logic                 grant_hit;
   logic                 exit_push;

   entry_t               mem [FIFO_DEPTH];
   entry_t               head;
   entry_t               push_data;
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          fifo_count;
   logic                 fifo_empty, fifo_full;
   logic                 push, pop;

   // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the first set bit.
   always_comb begin : rr_pick
      dbl_valid = {req.req_valid, req.req_valid};
      rot_valid = CORES'(dbl_valid >> rr_ptr);
      any_valid = 1'b0;
      winner    = '0;
      for (int unsigned k = 0; k < CORES; k++) begin
         if (!any_valid && rot_valid[k]) begin
            any_valid = 1'b1;
            winner    = CW'((32'(rr_ptr) + k) % CORES);
         end
      end
   end

   // Payload of the winning core.
   always_comb begin : sel_mux
      sel_hit   = 1'b0;
      sel_x     = '0;
      sel_y     = '0;
      sel_scale = '0;
      for (int unsigned k = 0; k < CORES; k++) begin
         if (winner == CW'(k)) begin
            sel_hit   = req.req_hit[k];
            sel_x     = req.req_x[k*XBITS +: XBITS];
            sel_y     = req.req_y[k*YBITS +: YBITS];
            sel_scale = req.req_scale[k*SCALEBITS +: SCALEBITS];
         end
      end
   end

   // Accept is combinational; suppressed while reset is asserted.
   assign req.req_ack = (grant_en && !reset) ? (CORES'(1) << winner) : '0;

   assign grant_hit = grant_en & sel_hit;
   assign push      = grant_hit | exit_push;

   always_comb begin : push_sel
      if (exit_push) begin
         push_data.x     = exit_x;
         push_data.y     = exit_y;
         push_data.scale = '0;
         push_data.ext   = 1'b1;
      end else begin
         push_data.x     = sel_x;
         push_data.y     = sel_y;
         push_data.scale = sel_scale;
         push_data.ext   = 1'b0;
      end
   end

   // FIFO status uses the registered count, so a same-cycle pop never frees a slot.
   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign pop        = !fifo_empty && ws.ws_ready;
   assign head       = mem[rd_ptr];

   // Head presented with fall-through; zeroed while empty so reset shows all-zero.
   assign ws.ws_valid = !fifo_empty;
   assign ws.ws_x     = fifo_empty ? '0 : head.x;
   assign ws.ws_y     = fifo_empty ? '0 : head.y;
   assign ws.ws_scale = fifo_empty ? '0 : head.scale;
   assign ws.ws_exit  = fifo_empty ? 1'b0 : head.ext;

   assign busy = (state != S_RUN) || !fifo_empty;

   // FIFO storage.
   always_ff @(posedge clk) begin : fifo_mem
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin : fifo_ctrl
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Round-robin pointer advances past each granted core.
   always_ff @(posedge clk or posedge reset) begin : rr_reg
      if (reset) begin
         rr_ptr <= '0;
      end else if (grant_en) begin
         rr_ptr <= (winner == CW'(CORES - 1)) ? '0 : winner + CW'(1);
      end
   end

   // Hit counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge reset) begin : hit_cnt
      if (reset) begin
         hit_count <= '0;
      end else if (clear) begin
         hit_count <= '0;
      end else if (grant_hit && (hit_count != 16'hFFFF)) begin
         hit_count <= hit_count + 16'd1;
      end
   end

`ifdef RESULT_ARB_STALL_CNT_EN
   // Cycles where the store holds off a valid head.
   always_ff @(posedge clk or posedge reset) begin : stall_cnt
      if (reset) begin
         stall_cycles <= '0;
      end else if (clear) begin
         stall_cycles <= '0;
      end else if (ws.ws_valid && !ws.ws_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin : fsm_reg
      if (reset) begin
         state <= S_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state.
   always_comb begin : fsm_next
      state_nxt = state;
      case (state)
         S_RUN:   if (exit_req) state_nxt = S_DRAIN;
         S_DRAIN: if ((req.req_valid == '0) && fifo_empty) state_nxt = S_EXIT;
         S_EXIT:  state_nxt = S_WAIT;
         S_WAIT:  if (pop && head.ext) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_RUN;
         default: state_nxt = S_RUN;
      endcase
   end

   // FSM outputs: grants only while running or draining.
   always_comb begin : fsm_out
      grant_en  = 1'b0;
      exit_push = 1'b0;
      exit_ack  = 1'b0;
      case (state)
         S_RUN,
         S_DRAIN: grant_en  = any_valid && !fifo_full;
         S_EXIT:  exit_push = 1'b1;
         S_DONE:  exit_ack  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_result_store_arbiter.sv
// Self-checking bench for result_store_arbiter: reset checks, a vector table for
// round-robin/miss/clear behaviour, hand sequences for backpressure, exit flush and
// async reset, then randomized traffic against a queue-based reference model.

module tb_result_store_arbiter;

   localparam int unsigned CORES      = 4;
   localparam int unsigned XBITS      = 10;
   localparam int unsigned YBITS      = 10;
   localparam int unsigned SCALEBITS  = 6;
   localparam int unsigned FIFO_DEPTH = 4;

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_EXIT  = 2;
   localparam int M_WAIT  = 3;
   localparam int M_DONE  = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             exit_req;
   logic [XBITS-1:0] exit_x;
   logic [YBITS-1:0] exit_y;
   logic             exit_ack;
   logic [15:0]      hit_count;
   logic             clear;
   logic             busy;
`ifdef RESULT_ARB_STALL_CNT_EN
   logic [31:0]      stall_cycles;
`endif

   rsa_req_if #(.CORES(CORES), .XBITS(XBITS), .YBITS(YBITS), .SCALEBITS(SCALEBITS)) req_bus ();
   rsa_ws_if  #(.XBITS(XBITS), .YBITS(YBITS), .SCALEBITS(SCALEBITS)) ws_bus ();

   result_store_arbiter #(
      .CORES(CORES), .XBITS(XBITS), .YBITS(YBITS),
      .SCALEBITS(SCALEBITS), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req_bus),
      .exit_req (exit_req),
      .exit_x   (exit_x),
      .exit_y   (exit_y),
      .exit_ack (exit_ack),
      .ws       (ws_bus),
      .hit_count(hit_count),
      .clear    (clear),
      .busy     (busy)
`ifdef RESULT_ARB_STALL_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned rx [CORES];
   int unsigned ry [CORES];
   int unsigned rs [CORES];

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  hit;
      logic        clr;
      logic [3:0]  exp_ack;
      logic [15:0] exp_hc;
      logic        exp_wv;
      logic [9:0]  exp_x;
   } vec_t;

   typedef struct {
      int unsigned x;
      int unsigned y;
      int unsigned s;
      bit          e;
   } mentry_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_inputs(input logic [3:0] v, input logic [3:0] h);
      req_bus.req_valid = v;
      req_bus.req_hit   = h;
      for (int i = 0; i < int'(CORES); i++) begin
         req_bus.req_x[i*XBITS +: XBITS]             = XBITS'(rx[i]);
         req_bus.req_y[i*YBITS +: YBITS]             = YBITS'(ry[i]);
         req_bus.req_scale[i*SCALEBITS +: SCALEBITS] = SCALEBITS'(rs[i]);
      end
   endtask

   task automatic set_fixed_data();
      for (int i = 0; i < int'(CORES); i++) begin
         rx[i] = i;
         ry[i] = 100 + i;
         rs[i] = i + 1;
      end
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      exit_req         = 1'b0;
      clear            = 1'b0;
      exit_x           = 10'h2A5;
      exit_y           = 10'h15A;
      ws_bus.ws_ready  = 1'b0;
      apply_inputs(4'hF, 4'hF);
      #1;
      check("rst_req_ack_forced", 32'(req_bus.req_ack), 32'h0);
      cyc();
      apply_inputs(4'h0, 4'h0);
      reset = 1'b0;
      #1;
      check("rst_ws_valid", 32'(ws_bus.ws_valid), 32'h0);
      check("rst_ws_x", 32'(ws_bus.ws_x), 32'h0);
      check("rst_ws_exit", 32'(ws_bus.ws_exit), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_hit_count", 32'(hit_count), 32'h0);
      check("rst_exit_ack", 32'(exit_ack), 32'h0);
   endtask

   vec_t tbl [11];

   // Reference-model state.
   mentry_t     q [$];
   int          m_phase;
   int          m_rr;
   int unsigned m_hc;
   longint unsigned m_stall;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- vector table ----------------
      tbl[0]  = '{4'hF, 4'hF, 1'b0, 4'b0001, 16'd1, 1'b1, 10'd0};
      tbl[1]  = '{4'hF, 4'hF, 1'b0, 4'b0010, 16'd2, 1'b1, 10'd1};
      tbl[2]  = '{4'hF, 4'hF, 1'b0, 4'b0100, 16'd3, 1'b1, 10'd2};
      tbl[3]  = '{4'hF, 4'hF, 1'b0, 4'b1000, 16'd4, 1'b1, 10'd3};
      tbl[4]  = '{4'hF, 4'hF, 1'b0, 4'b0001, 16'd5, 1'b1, 10'd0};
      tbl[5]  = '{4'h4, 4'h0, 1'b0, 4'b0100, 16'd5, 1'b0, 10'd0};
      tbl[6]  = '{4'h0, 4'h0, 1'b0, 4'b0000, 16'd5, 1'b0, 10'd0};
      tbl[7]  = '{4'h3, 4'h3, 1'b0, 4'b0001, 16'd6, 1'b1, 10'd0};
      tbl[8]  = '{4'h3, 4'h3, 1'b0, 4'b0010, 16'd7, 1'b1, 10'd1};
      tbl[9]  = '{4'h1, 4'h1, 1'b1, 4'b0001, 16'd0, 1'b1, 10'd0};
      tbl[10] = '{4'h0, 4'h0, 1'b0, 4'b0000, 16'd0, 1'b0, 10'd0};

      set_fixed_data();
      do_reset();
      ws_bus.ws_ready = 1'b1;
      for (int r = 0; r < 11; r++) begin
         clear = tbl[r].clr;
         apply_inputs(tbl[r].valid, tbl[r].hit);
         #1;
         check($sformatf("tbl%0d_ack", r), 32'(req_bus.req_ack), 32'(tbl[r].exp_ack));
         cyc();
         check($sformatf("tbl%0d_hit_count", r), 32'(hit_count), 32'(tbl[r].exp_hc));
         check($sformatf("tbl%0d_ws_valid", r), 32'(ws_bus.ws_valid), 32'(tbl[r].exp_wv));
         if (tbl[r].exp_wv) begin
            check($sformatf("tbl%0d_ws_x", r), 32'(ws_bus.ws_x), 32'(tbl[r].exp_x));
         end
      end
      clear = 1'b0;

      // ---------------- backpressure ----------------
      do_reset();
      ws_bus.ws_ready = 1'b0;
      begin
         logic [3:0] bp_exp [6];
         int         acks;
         bp_exp[0] = 4'b0001; bp_exp[1] = 4'b0010; bp_exp[2] = 4'b0100;
         bp_exp[3] = 4'b1000; bp_exp[4] = 4'b0000; bp_exp[5] = 4'b0000;
         acks = 0;
         for (int i = 0; i < 6; i++) begin
            apply_inputs(4'hF, 4'hF);
            #1;
            check($sformatf("bp_ack%0d", i), 32'(req_bus.req_ack), 32'(bp_exp[i]));
            acks += $countones(req_bus.req_ack);
            cyc();
         end
         check("bp_total_acks", 32'(acks), 32'd4);
      end
      // Pop while full: slot not usable for a grant in the same cycle.
      ws_bus.ws_ready = 1'b1;
      #1;
      check("bp_full_pop_ack", 32'(req_bus.req_ack), 32'h0);
      check("bp_head0_x", 32'(ws_bus.ws_x), 32'd0);
      cyc();
      #1;
      check("bp_after_pop_ack", 32'(req_bus.req_ack), 32'b0001);
      check("bp_head1_x", 32'(ws_bus.ws_x), 32'd1);
      check("bp_head1_y", 32'(ws_bus.ws_y), 32'd101);
      cyc();
      apply_inputs(4'h0, 4'h0);
      begin
         int unsigned order [3];
         order[0] = 2; order[1] = 3; order[2] = 0;
         for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_order%0d_valid", i), 32'(ws_bus.ws_valid), 32'h1);
            check($sformatf("bp_order%0d_x", i), 32'(ws_bus.ws_x), 32'(order[i]));
            cyc();
         end
      end
      check("bp_empty_after", 32'(ws_bus.ws_valid), 32'h0);
      check("bp_hit_count", 32'(hit_count), 32'd5);

      // ---------------- exit flush ----------------
      do_reset();
      ws_bus.ws_ready = 1'b0;
      apply_inputs(4'b0001, 4'hF);
      cyc();
      apply_inputs(4'b0100, 4'hF);
      cyc();
      apply_inputs(4'b0010, 4'hF);
      exit_req = 1'b1;
      #1;
      check("ex_core1_ack", 32'(req_bus.req_ack), 32'b0010);
      cyc();
      exit_req = 1'b0;
      apply_inputs(4'h0, 4'h0);
      ws_bus.ws_ready = 1'b1;
      check("ex_busy_drain", 32'(busy), 32'h1);
      begin
         int unsigned dorder [3];
         bit          found;
         dorder[0] = 0; dorder[1] = 2; dorder[2] = 1;
         for (int i = 0; i < 3; i++) begin
            check($sformatf("ex_drain%0d_valid", i), 32'(ws_bus.ws_valid), 32'h1);
            check($sformatf("ex_drain%0d_x", i), 32'(ws_bus.ws_x), 32'(dorder[i]));
            check($sformatf("ex_drain%0d_exit", i), 32'(ws_bus.ws_exit), 32'h0);
            cyc();
         end
         found = 1'b0;
         for (int i = 0; i < 10 && !found; i++) begin
            check($sformatf("ex_wait%0d_exit_ack", i), 32'(exit_ack), 32'h0);
            if (ws_bus.ws_valid) found = 1'b1;
            else cyc();
         end
         check("ex_record_seen", 32'(found), 32'h1);
         check("ex_record_exit", 32'(ws_bus.ws_exit), 32'h1);
         check("ex_record_x", 32'(ws_bus.ws_x), 32'h2A5);
         check("ex_record_y", 32'(ws_bus.ws_y), 32'h15A);
         check("ex_record_scale", 32'(ws_bus.ws_scale), 32'h0);
         cyc();
         check("ex_exit_ack_pulse", 32'(exit_ack), 32'h1);
         check("ex_busy_done", 32'(busy), 32'h1);
         cyc();
         check("ex_exit_ack_low", 32'(exit_ack), 32'h0);
         check("ex_busy_idle", 32'(busy), 32'h0);
         check("ex_hit_count", 32'(hit_count), 32'd3);
      end

      // ---------------- async reset while waiting on exit record ----------------
      do_reset();
      ws_bus.ws_ready = 1'b0;
      exit_req = 1'b1;
      cyc();
      exit_req = 1'b0;
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 10 && !found; i++) begin
            if (ws_bus.ws_valid && ws_bus.ws_exit) found = 1'b1;
            else cyc();
         end
         check("ar_reached_wait", 32'(found), 32'h1);
      end
      apply_inputs(4'hF, 4'hF);
      #2;
      reset = 1'b1;
      #1;
      check("ar_ws_valid", 32'(ws_bus.ws_valid), 32'h0);
      check("ar_busy", 32'(busy), 32'h0);
      check("ar_req_ack", 32'(req_bus.req_ack), 32'h0);
      cyc();
      reset = 1'b0;
      apply_inputs(4'h0, 4'h0);
      ws_bus.ws_ready = 1'b1;
      begin
         int ack_seen;
         ack_seen = 0;
         for (int i = 0; i < 6; i++) begin
            #1;
            if (exit_ack) ack_seen++;
            cyc();
         end
         check("ar_no_exit_ack", 32'(ack_seen), 32'h0);
      end

      // ---------------- randomized traffic vs reference model ----------------
      do_reset();
      q.delete();
      m_phase = M_RUN;
      m_rr    = 0;
      m_hc    = 0;
      m_stall = 0;
      for (int c = 0; c < 1200; c++) begin
         logic [3:0]  v, h;
         int unsigned dens;
         bit          mv, grant, rdy, pushed_hit;
         int          win;
         int          pre_size;
         logic [3:0]  exp_ack;

         dens = ((c / 150) % 2 == 1) ? 70 : 25;
         for (int i = 0; i < int'(CORES); i++) begin
            v[i]  = ($urandom_range(0, 99) < dens);
            h[i]  = ($urandom_range(0, 3) != 0);
            rx[i] = $urandom_range(0, 1023);
            ry[i] = $urandom_range(0, 1023);
            rs[i] = $urandom_range(0, 63);
         end
         rdy             = ($urandom_range(0, 99) < 60);
         ws_bus.ws_ready = rdy;
         clear           = ($urandom_range(0, 99) < 4);
         exit_req        = ($urandom_range(0, 99) < 4);
         exit_x          = XBITS'($urandom_range(0, 1023));
         exit_y          = YBITS'($urandom_range(0, 1023));
         apply_inputs(v, h);
         #1;

         pre_size = q.size();
         mv       = (pre_size > 0);
         grant    = ((m_phase == M_RUN) || (m_phase == M_DRAIN)) &&
                    (pre_size < int'(FIFO_DEPTH)) && (v != 4'h0);
         win      = 0;
         if (grant) begin
            for (int k = int'(CORES) - 1; k >= 0; k--) begin
               if (v[(m_rr + k) % int'(CORES)]) win = (m_rr + k) % int'(CORES);
            end
         end
         exp_ack = grant ? (4'b0001 << win) : 4'b0000;

         check("rnd_ack", 32'(req_bus.req_ack), 32'(exp_ack));
         check("rnd_ws_valid", 32'(ws_bus.ws_valid), 32'(mv));
         if (mv) begin
            check("rnd_ws_x", 32'(ws_bus.ws_x), q[0].x);
            check("rnd_ws_y", 32'(ws_bus.ws_y), q[0].y);
            check("rnd_ws_scale", 32'(ws_bus.ws_scale), q[0].s);
            check("rnd_ws_exit", 32'(ws_bus.ws_exit), 32'(q[0].e));
         end
         check("rnd_hit_count", 32'(hit_count), m_hc);
         check("rnd_busy", 32'(busy), 32'((m_phase != M_RUN) || mv));
         check("rnd_exit_ack", 32'(exit_ack), 32'(m_phase == M_DONE));
`ifdef RESULT_ARB_STALL_CNT_EN
         check("rnd_stall", stall_cycles, 32'(m_stall));
`endif

         // Advance the model across the coming clock edge.
         if (mv && rdy) void'(q.pop_front());
         pushed_hit = grant && h[win];
         if (pushed_hit) begin
            mentry_t e;
            e.x = rx[win]; e.y = ry[win]; e.s = rs[win]; e.e = 1'b0;
            q.push_back(e);
         end
         case (m_phase)
            M_RUN:   if (exit_req) m_phase = M_DRAIN;
            M_DRAIN: if ((v == 4'h0) && (pre_size == 0)) m_phase = M_EXIT;
            M_EXIT: begin
               mentry_t e;
               e.x = exit_x; e.y = exit_y; e.s = 0; e.e = 1'b1;
               q.push_back(e);
               m_phase = M_WAIT;
            end
            M_WAIT:  if (mv && rdy) m_phase = M_DONE;
            default: m_phase = M_RUN;
         endcase
         if (clear) m_hc = 0;
         else if (pushed_hit && m_hc < 65535) m_hc++;
         if (clear) m_stall = 0;
         else if (mv && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (grant) m_rr = (win + 1) % int'(CORES);

         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
